// File: rtl/cavity_drive_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cavity_drive_seq: pulse-envelope sequencer (impulse/fill/flat/decay)     |
// | scaling a coherent sine-LUT stream. Option: CAVITY_DRIVE_SEQ_ROUND_EN.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module cavity_drive_seq #(
    parameter int DW      = 16,
    parameter int AW      = 6,
    parameter int PH_STEP = 7,
    parameter int PH_MOD  = 33,
    parameter int IMP_AMP = 30000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          imp_en,
    input  logic [15:0]   fill_len,
    input  logic [15:0]   flat_len,
    input  logic [15:0]   ramp_step,
    input  logic [14:0]   amp_set,
    output logic [AW-1:0] lut_addr,
    input  logic [DW-1:0] lut_data,
    output logic [DW-1:0] drive,
    output logic          busy,
    output logic [2:0]    state,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_IMPULSE = 3'd1,
        S_FILL    = 3'd2,
        S_FLAT    = 3'd3,
        S_DECAY   = 3'd4
    } state_t;

    localparam int                     c_pw      = DW + 16;
    localparam logic [AW:0]            c_ph_step = (AW+1)'(PH_STEP);
    localparam logic [AW:0]            c_ph_mod  = (AW+1)'(PH_MOD);
    localparam logic signed [DW-1:0]   c_imp_amp = DW'(IMP_AMP);

    state_t          state_q, state_d, st1_q, st1_d;
    logic [14:0]     amp_q, amp_d, amp1_q, amp1_d;
    logic [AW-1:0]   phase_q, phase_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [DW-1:0]   drive_q, drive_d;

    logic [15:0]     w_fill_src, w_enter_cnt;
    state_t          w_enter_st, w_flat_st;
    logic [16:0]     w_ramp_sum;
    logic [AW:0]     w_ph_sum, w_ph_wrap;
    logic signed [c_pw-1:0] w_prod;
    logic [DW-1:0]   w_drive_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            amp_q   <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            amp1_q  <= '0;
            st1_q   <= S_IDLE;
            drive_q <= '0;
        end else begin
            state_q <= state_d;
            amp_q   <= amp_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            amp1_q  <= amp1_d;
            st1_q   <= st1_d;
            drive_q <= drive_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        amp_d      = amp_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        w_ramp_sum = {2'b0, amp_q} + {1'b0, ramp_step};
        // Zero-length phases are skipped, so leaving IDLE/IMPULSE may land in FILL, FLAT or DECAY
        w_fill_src = (state_q == S_IDLE) ? fill_len : cnt_q;
        if (w_fill_src != '0) begin
            w_enter_st  = S_FILL;
            w_enter_cnt = w_fill_src;
        end else if (flat_len != '0) begin
            w_enter_st  = S_FLAT;
            w_enter_cnt = flat_len;
        end else begin
            w_enter_st  = S_DECAY;
            w_enter_cnt = '0;
        end
        w_flat_st = (flat_len != '0) ? S_FLAT : S_DECAY;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = imp_en ? S_IMPULSE : w_enter_st;
                    cnt_d   = imp_en ? fill_len : w_enter_cnt;
                    amp_d   = '0;
                end
            end
            S_IMPULSE: begin
                state_d = abort ? S_DECAY : w_enter_st;
                cnt_d   = w_enter_cnt;
            end
            S_FILL: begin
                amp_d = (w_ramp_sum > {2'b0, amp_set}) ? amp_set : w_ramp_sum[14:0];
                if (abort) begin
                    state_d = S_DECAY;
                end else if (cnt_q <= 16'd1) begin
                    state_d = w_flat_st;
                    cnt_d   = flat_len;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_FLAT: begin
                amp_d = amp_set;
                if (abort || cnt_q <= 16'd1) begin
                    state_d = S_DECAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DECAY: begin
                if (amp_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (ramp_step == '0 || ramp_step >= {1'b0, amp_q}) begin
                    amp_d = '0;
                end else begin
                    amp_d = amp_q - ramp_step[14:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                amp_d   = '0;
                cnt_d   = '0;
            end
        endcase

        w_ph_sum  = {1'b0, phase_q} + c_ph_step;
        w_ph_wrap = (w_ph_sum >= c_ph_mod) ? (w_ph_sum - c_ph_mod) : w_ph_sum;
        phase_d   = (state_q == S_IDLE || state_d == S_IDLE) ? '0 : w_ph_wrap[AW-1:0];

        amp1_d  = amp_q;
        st1_d   = state_q;
        drive_d = (st1_q == S_IMPULSE) ? c_imp_amp : w_drive_prod;
    end

    assign w_prod = $signed(lut_data) * $signed({1'b0, amp1_q});

`ifdef CAVITY_DRIVE_SEQ_ROUND_EN
    localparam logic signed [c_pw-1:0] c_half    = c_pw'(2**(DW-2));
    localparam logic signed [c_pw-DW:0] c_sat_max = (c_pw-DW+1)'(2**(DW-1)-1);
    logic signed [c_pw-1:0] w_rnd;
    logic signed [c_pw-DW:0] w_scaled;
    logic w_unused;
    assign w_rnd        = w_prod + c_half;
    assign w_scaled     = w_rnd[c_pw-1:DW-1];
    assign w_drive_prod = (w_scaled > c_sat_max) ? c_sat_max[DW-1:0] : w_scaled[DW-1:0];
    assign w_unused     = ^{w_rnd[DW-2:0], w_ph_wrap[AW]};
`else
    logic w_unused;
    assign w_drive_prod = w_prod[DW-1 +: DW];
    assign w_unused     = ^{w_prod[DW-2:0], w_prod[c_pw-1], w_ph_wrap[AW]};
`endif

    assign lut_addr = phase_q;
    assign drive    = drive_q;
    assign busy     = (state_q != S_IDLE);
    assign state    = state_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cavity_drive_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cavity_drive_seq: table, directed and random pulses vs envelope model |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_cavity_drive_seq;

    localparam int DW = 16, AW = 6, PH_STEP = 7, PH_MOD = 33, IMP_AMP = 30000;
`ifdef CAVITY_DRIVE_SEQ_ROUND_EN
    localparam int c_round_exp = 1;
`else
    localparam int c_round_exp = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, abort, imp_en;
    logic [15:0]   fill_len, flat_len, ramp_step;
    logic [14:0]   amp_set;
    logic [AW-1:0] lut_addr;
    logic [DW-1:0] lut_data;
    logic [DW-1:0] drive;
    logic          busy, done;
    logic [2:0]    state;

    cavity_drive_seq #(.DW(DW), .AW(AW), .PH_STEP(PH_STEP), .PH_MOD(PH_MOD), .IMP_AMP(IMP_AMP)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .imp_en(imp_en),
        .fill_len(fill_len), .flat_len(flat_len), .ramp_step(ramp_step), .amp_set(amp_set),
        .lut_addr(lut_addr), .lut_data(lut_data), .drive(drive), .busy(busy),
        .state(state), .done(done)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  lut_mem [PH_MOD];
    bit  lut_force = 1'b0;
    int  force_val = 16385;
    int  exp_st[$];
    int  exp_amp[$];

    // Registered sine ROM with one clock of latency
    always @(posedge clk) begin
        if (lut_force)                      lut_data <= DW'(force_val);
        else if (int'(lut_addr) < PH_MOD)   lut_data <= DW'(lut_mem[int'(lut_addr)]);
        else                                lut_data <= '0;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    function automatic int exp_drive(input int st, input int amp, input int ph);
        int lv, p, r;
        if (st == 1) return IMP_AMP;
        lv = lut_force ? force_val : lut_mem[ph];
        p  = lv * amp;
`ifdef CAVITY_DRIVE_SEQ_ROUND_EN
        r = (p + 16384) >>> 15;
        if (r > 32767) r = 32767;
`else
        r = p >>> 15;
`endif
        return r;
    endfunction

    // Envelope for one pulse: one (state, amplitude) entry per busy cycle.
    // ab >= 0 aborts on that busy cycle if it is in IMPULSE/FILL/FLAT.
    task automatic build(input bit imp, input int fl, input int ftl, input int step,
                         input int set, input int ab);
        int  amp;
        bit  aborted;
        exp_st.delete();
        exp_amp.delete();
        amp = 0;
        aborted = 1'b0;
        if (imp) begin
            exp_st.push_back(1); exp_amp.push_back(amp);
            if (ab == 0) aborted = 1'b1;
        end
        for (int i = 0; i < fl && !aborted; i++) begin
            exp_st.push_back(2); exp_amp.push_back(amp);
            amp = (amp + step > set) ? set : amp + step;
            if (exp_st.size() - 1 == ab) aborted = 1'b1;
        end
        for (int i = 0; i < ftl && !aborted; i++) begin
            exp_st.push_back(3); exp_amp.push_back(amp);
            amp = set;
            if (exp_st.size() - 1 == ab) aborted = 1'b1;
        end
        forever begin
            exp_st.push_back(4); exp_amp.push_back(amp);
            if (amp == 0) break;
            amp = (step == 0 || step >= amp) ? 0 : amp - step;
        end
    endtask

    // ab = -1: no abort; ab = -2: abort raised together with start
    task automatic run_pulse(input bit imp, input int fl, input int ftl, input int step,
                             input int set, input int ab, input bit start_in_decay,
                             output int busy_cnt);
        int n, j, ed;
        build(imp, fl, ftl, step, set, ab);
        n = exp_st.size();
        @(negedge clk);
        imp_en = imp; fill_len = 16'(fl); flat_len = 16'(ftl);
        ramp_step = 16'(step); amp_set = 15'(set);
        start = 1'b1;
        abort = (ab == -2);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < n + 4; k++) begin
            if (k < n) begin
                check("state", int'(state), exp_st[k]);
                check("lut_addr", int'(lut_addr), (k * PH_STEP) % PH_MOD);
                check("done_low", int'(done), 0);
            end else begin
                check("state_idle", int'(state), 0);
                check("done", int'(done), (k == n) ? 1 : 0);
                check("lut_addr_idle", int'(lut_addr), 0);
            end
            check("busy", int'(busy), (k < n) ? 1 : 0);
            busy_cnt += int'(busy);
            j  = k - 2;
            ed = (j >= 0 && j < n) ? exp_drive(exp_st[j], exp_amp[j], (j * PH_STEP) % PH_MOD) : 0;
            check("drive", int'($signed(drive)), ed);
            abort = (ab >= 0 && k == ab);
            start = start_in_decay && (k < n) && (exp_st[k] == 4);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    typedef struct {
        bit imp;
        int fl;
        int ftl;
        int step;
        int set;
        int ab;
        bit sid;
        int exp_busy;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int bc;
        real r;
        vecs[0] = '{1'b1, 0,   0, 1000,     0, -1, 1'b0,   2};  // impulse only
        vecs[1] = '{1'b0, 10,  4, 1000,  5500, -1, 1'b0,  21};  // ramp up/hold/ramp down
        vecs[2] = '{1'b0, 0, 100, 32767, 32767, -1, 1'b0, 102}; // coherent phase over flat-top
        vecs[3] = '{1'b0, 2,   6, 3000,  9000,  4, 1'b1,   9};  // abort in 3rd FLAT cycle
        vecs[4] = '{1'b0, 2,   6, 3000,  9000,  4, 1'b1,   9};  // restart after done
        vecs[5] = '{1'b1, 2,   3, 0,      100, -1, 1'b0,   8};  // ramp_step 0
        vecs[6] = '{1'b0, 3,   0, 20000, 32767, -1, 1'b0,   6};  // clamp, flat skipped
        vecs[7] = '{1'b0, 1,   2, 16000, 16000, -2, 1'b0,   5};  // start wins over abort
        vecs[8] = '{1'b1, 5,   5, 100,   1000,  0, 1'b0,   2};  // abort during impulse

        for (int i = 0; i < PH_MOD; i++) begin
            r = 32767.0 * $sin(2.0 * 3.14159265358979 * i / PH_MOD);
            lut_mem[i] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        end

        rst = 1'b1; start = 1'b1; abort = 1'b0; imp_en = 1'b0;
        fill_len = '0; flat_len = '0; ramp_step = '0; amp_set = '0;
        repeat (3) begin
            @(negedge clk);
            check("rst_state", int'(state), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_drive", int'(drive), 0);
            check("rst_lut_addr", int'(lut_addr), 0);
            check("rst_done", int'(done), 0);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("idle_state", int'(state), 0);
            check("idle_busy", int'(busy), 0);
            check("idle_drive", int'(drive), 0);
            check("idle_lut_addr", int'(lut_addr), 0);
            check("idle_done", int'(done), 0);
        end

        for (int i = 0; i < 9; i++) begin
            run_pulse(vecs[i].imp, vecs[i].fl, vecs[i].ftl, vecs[i].step, vecs[i].set,
                      vecs[i].ab, vecs[i].sid, bc);
            check("vec_busy_len", bc, vecs[i].exp_busy);
        end

        // Reset mid-FILL: back to IDLE at that edge, no done afterwards
        @(negedge clk);
        imp_en = 1'b0; fill_len = 16'd10; flat_len = 16'd4; ramp_step = 16'd1000; amp_set = 15'd5500;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_fill", int'(state), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_drive", int'(drive), 0);
        check("mid_rst_busy", int'(busy), 0);
        repeat (6) begin
            check("mid_rst_no_done", int'(done), 0);
            check("mid_rst_drive_after", int'(drive), 0);
            @(negedge clk);
        end

        // Rounding: lut_data 16385 at amp 1
        lut_force = 1'b1;
        fill_len = 16'd0; flat_len = 16'd6; ramp_step = 16'd1; amp_set = 15'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("round_drive", int'($signed(drive)), c_round_exp);
        repeat (12) @(negedge clk);
        check("round_back_idle", int'(state), 0);
        lut_force = 1'b0;

        for (int it = 0; it < 30; it++) begin
            int fl, ftl, st, sa, ab, sel;
            bit imp, sid;
            imp = 1'($urandom % 2);
            fl  = int'($urandom % 13);
            ftl = int'($urandom % 13);
            sa  = int'($urandom % 32768);
            st  = ($urandom % 8 == 0) ? 0 : 500 + int'($urandom % 20000);
            sel = int'($urandom % 4);
            ab  = (sel == 0) ? -1 : (sel == 1) ? -2 : int'($urandom % (1 + fl + ftl + imp));
            sid = 1'($urandom % 2);
            run_pulse(imp, fl, ftl, st, sa, ab, sid, bc);
            check("rand_busy_len", bc, exp_st.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog at %0t: actual=timeout required=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
